pll_lock_ctrl: RTL and testbench

Startup and lock supervisor for `pll_top`. Holds the PLL in reset for a fixed time, then releases it and qualifies `locked` over a run of consecutive cycles. Only after qualification does it enable the downstream clock output. It re-acquires on loss of lock and, optionally, retries on acquisition timeout until it declares failure.

---
 rtl/pll_lock_ctrl.sv | 177 +++++++++++++++++
 tb/tb_pll_lock_ctrl.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pll_lock_ctrl.sv
// PLL reset/lock supervisor: hold, acquire, qualify, run; all outputs are registered decodes of the next state (1-cycle latency, no backpressure).
// Build with PLL_LOCK_CTRL_TIMEOUT_EN for acquisition timeout, retry counting and the FAIL state.
module pll_lock_ctrl #(
    parameter int unsigned RST_CYC     = 16,
    parameter int unsigned LOCK_CNT    = 256,
    parameter int unsigned TIMEOUT_CYC = 65536,
    parameter int unsigned MAX_RETRY   = 3,
    parameter int unsigned CW          = 17
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       restart,
    input  logic       pll_locked,
    output logic       pll_rst_n,
    output logic       out_en,
    output logic       ready,
    output logic       fail,
    output logic       lol,
    output logic [3:0] retries,
    output logic [2:0] state
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_HOLD = 3'd1,
        S_ACQ  = 3'd2,
        S_RUN  = 3'd3,
        S_FAIL = 3'd4
    } state_t;

    localparam logic [CW-1:0] ONE       = CW'(1);
    localparam logic [CW-1:0] RST_LAST  = CW'(RST_CYC - 1);
    localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_CNT - 1);

    if (RST_CYC < 1 || LOCK_CNT < 1 || MAX_RETRY > 15 ||
        RST_CYC >= (64'd1 << CW) || LOCK_CNT >= (64'd1 << CW) ||
        TIMEOUT_CYC >= (64'd1 << CW)) begin : g_bad_cfg
        $error("pll_lock_ctrl: parameter out of range");
    end

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          lol_q, lol_d;
    logic          pll_rst_n_q, run_q;

`ifdef PLL_LOCK_CTRL_TIMEOUT_EN
    localparam logic [CW-1:0] TO_LAST   = CW'(TIMEOUT_CYC - 1);
    localparam logic [3:0]    RETRY_MAX = 4'(MAX_RETRY);

    logic [CW-1:0] tcnt_q, tcnt_d;
    logic [3:0]    retries_q, retries_d;
    logic          fail_q;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lol_d   = lol_q;
`ifdef PLL_LOCK_CTRL_TIMEOUT_EN
        tcnt_d    = tcnt_q;
        retries_d = retries_q;
`endif
        if (!en) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            lol_d   = 1'b0;
`ifdef PLL_LOCK_CTRL_TIMEOUT_EN
            tcnt_d    = '0;
            retries_d = '0;
`endif
        end else if (restart) begin
            state_d = S_HOLD;
            cnt_d   = '0;
            lol_d   = 1'b0;
`ifdef PLL_LOCK_CTRL_TIMEOUT_EN
            tcnt_d    = '0;
            retries_d = '0;
`endif
        end else begin
            case (state_q)
                S_IDLE: begin
                    state_d = S_HOLD;
                    cnt_d   = '0;
                end
                S_HOLD: begin
                    if (cnt_q == RST_LAST) begin
                        state_d = S_ACQ;
                        cnt_d   = '0;
`ifdef PLL_LOCK_CTRL_TIMEOUT_EN
                        tcnt_d = '0;
`endif
                    end else begin
                        cnt_d = cnt_q + ONE;
                    end
                end
                S_ACQ: begin
                    // Any low sample restarts qualification: lock must be consecutive.
                    cnt_d = pll_locked ? cnt_q + ONE : '0;
`ifdef PLL_LOCK_CTRL_TIMEOUT_EN
                    tcnt_d = tcnt_q + ONE;
`endif
                    if (pll_locked && cnt_q == LOCK_LAST) begin
                        state_d = S_RUN;
                        cnt_d   = '0;
`ifdef PLL_LOCK_CTRL_TIMEOUT_EN
                        retries_d = '0;
                    end else if (tcnt_q == TO_LAST) begin
                        cnt_d  = '0;
                        tcnt_d = '0;
                        if (retries_q == RETRY_MAX) begin
                            state_d = S_FAIL;
                        end else begin
                            state_d   = S_HOLD;
                            retries_d = retries_q + 4'd1;
                        end
`endif
                    end
                end
                S_RUN: begin
                    if (!pll_locked) begin
                        state_d = S_HOLD;
                        cnt_d   = '0;
                        lol_d   = 1'b1;
                    end
                end
                S_FAIL: begin
                    state_d = S_FAIL;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            lol_q       <= 1'b0;
            pll_rst_n_q <= 1'b0;
            run_q       <= 1'b0;
`ifdef PLL_LOCK_CTRL_TIMEOUT_EN
            tcnt_q    <= '0;
            retries_q <= '0;
            fail_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            lol_q       <= lol_d;
            pll_rst_n_q <= (state_d == S_ACQ) || (state_d == S_RUN);
            run_q       <= (state_d == S_RUN);
`ifdef PLL_LOCK_CTRL_TIMEOUT_EN
            tcnt_q    <= tcnt_d;
            retries_q <= retries_d;
            fail_q    <= (state_d == S_FAIL);
`endif
        end
    end

    assign pll_rst_n = pll_rst_n_q;
    assign out_en    = run_q;
    assign ready     = run_q;
    assign lol       = lol_q;
    assign state     = state_q;
`ifdef PLL_LOCK_CTRL_TIMEOUT_EN
    assign fail    = fail_q;
    assign retries = retries_q;
`else
    assign fail    = 1'b0;
    assign retries = 4'd0;
`endif

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Bench for pll_lock_ctrl: directed scenarios plus randomized traffic against an event-level reference model.
module tb_pll_lock_ctrl;

    localparam int RST  = 16;
    localparam int LOCK = 256;
    localparam int MAXR = 3;
`ifdef PLL_LOCK_CTRL_TIMEOUT_EN
    localparam int TMO   = 1000;
    localparam bit TO_EN = 1'b1;
`else
    localparam int TMO   = 65536;
    localparam bit TO_EN = 1'b0;
`endif
    localparam int M_IDLE = 0, M_HOLD = 1, M_ACQ = 2, M_RUN = 3, M_FAIL = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       restart = 1'b0;
    logic       pll_locked = 1'b0;
    logic       pll_rst_n, out_en, ready, fail, lol;
    logic [3:0] retries;
    logic [2:0] state;

    int total = 0;
    int bad   = 0;

    // Reference model: current phase plus elapsed-time / streak bookkeeping.
    int m_mode, m_hold, m_streak, m_age, m_ret;
    bit m_lol;

    always #5 clk = ~clk;

    pll_lock_ctrl #(
        .RST_CYC(RST), .LOCK_CNT(LOCK), .TIMEOUT_CYC(TMO), .MAX_RETRY(MAXR), .CW(17)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .restart(restart), .pll_locked(pll_locked),
        .pll_rst_n(pll_rst_n), .out_en(out_en), .ready(ready), .fail(fail),
        .lol(lol), .retries(retries), .state(state)
    );

    function automatic void model_reset();
        m_mode = M_IDLE; m_hold = 0; m_streak = 0; m_age = 0; m_ret = 0; m_lol = 1'b0;
    endfunction

    function automatic void model_step();
        if (!en) begin
            m_mode = M_IDLE; m_ret = 0; m_lol = 1'b0;
        end else if (restart) begin
            m_mode = M_HOLD; m_hold = 0; m_ret = 0; m_lol = 1'b0;
        end else if (m_mode == M_IDLE) begin
            m_mode = M_HOLD; m_hold = 0;
        end else if (m_mode == M_HOLD) begin
            m_hold++;
            if (m_hold == RST) begin
                m_mode = M_ACQ; m_streak = 0; m_age = 0;
            end
        end else if (m_mode == M_ACQ) begin
            m_age++;
            m_streak = pll_locked ? m_streak + 1 : 0;
            if (m_streak == LOCK) begin
                m_mode = M_RUN; m_ret = 0;
            end else if (TO_EN && m_age == TMO) begin
                if (m_ret == MAXR) m_mode = M_FAIL;
                else begin
                    m_ret++; m_mode = M_HOLD; m_hold = 0;
                end
            end
        end else if (m_mode == M_RUN) begin
            if (!pll_locked) begin
                m_mode = M_HOLD; m_hold = 0; m_lol = 1'b1;
            end
        end
    endfunction

    task automatic cyc();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b0; restart = 1'b0; pll_locked = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (state !== 3'd0)     begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
        total++; if (pll_rst_n !== 1'b0) begin bad++; $display("FAIL reset_pll_rst_n: got %b want 0", pll_rst_n); end
        total++; if ({out_en, ready, fail, lol} !== 4'b0) begin bad++; $display("FAIL reset_flags: got %b want 0000", {out_en, ready, fail, lol}); end
        total++; if (retries !== 4'd0)   begin bad++; $display("FAIL reset_retries: got %0d want 0", retries); end
        rst_n = 1'b1;
        cyc();
        total++; if (state !== 3'd0)     begin bad++; $display("FAIL idle_hold_en_low: got %0d want 0", state); end
    endtask

    task automatic test_startup();
        int n, k;
        en = 1'b1; pll_locked = 1'b1;
        cyc();
        total++; if (state !== 3'd1) begin bad++; $display("FAIL startup_hold: got %0d want 1", state); end
        n = 0;
        while (pll_rst_n !== 1'b1 && n < 100) begin n++; cyc(); end
        total++; if (n != RST) begin bad++; $display("FAIL startup_rst_low_cycles: got %0d want %0d", n, RST); end
        total++; if (state !== 3'd2) begin bad++; $display("FAIL startup_acq: got %0d want 2", state); end
        k = 0;
        while (ready !== 1'b1 && k < 1000) begin cyc(); k++; end
        total++; if (k != LOCK) begin bad++; $display("FAIL startup_lock_cycles: got %0d want %0d", k, LOCK); end
        total++; if ({state, out_en, retries} !== {3'd3, 1'b1, 4'd0}) begin bad++; $display("FAIL startup_run: got %h want %h", {state, out_en, retries}, {3'd3, 1'b1, 4'd0}); end
    endtask

    task automatic test_streak();
        int k;
        restart = 1'b1; cyc(); restart = 1'b0;
        total++; if ({state, lol} !== {3'd1, 1'b0}) begin bad++; $display("FAIL restart_from_run: got %h want %h", {state, lol}, {3'd1, 1'b0}); end
        repeat (RST) cyc();
        repeat (200) cyc();
        pll_locked = 1'b0; cyc();
        total++; if (state !== 3'd2) begin bad++; $display("FAIL streak_break_stays_acq: got %0d want 2", state); end
        pll_locked = 1'b1;
        k = 0;
        while (ready !== 1'b1 && k < 1000) begin cyc(); k++; end
        total++; if (k != LOCK) begin bad++; $display("FAIL streak_relock_cycles: got %0d want %0d", k, LOCK); end
    endtask

    task automatic test_lol();
        int k;
        pll_locked = 1'b0; cyc(); pll_locked = 1'b1;
        total++; if ({state, ready, out_en, pll_rst_n, lol} !== {3'd1, 4'b0001}) begin bad++; $display("FAIL lol_drop: got %h want %h", {state, ready, out_en, pll_rst_n, lol}, {3'd1, 4'b0001}); end
        k = 0;
        while (ready !== 1'b1 && k < 1000) begin cyc(); k++; end
        total++; if (k != RST + LOCK) begin bad++; $display("FAIL lol_reacquire_cycles: got %0d want %0d", k, RST + LOCK); end
        total++; if (lol !== 1'b1) begin bad++; $display("FAIL lol_sticky: got %b want 1", lol); end
    endtask

    task automatic test_en_restart();
        int n;
        restart = 1'b1; cyc(); restart = 1'b0;
        total++; if ({state, lol} !== {3'd1, 1'b0}) begin bad++; $display("FAIL restart_clears_lol: got %h want %h", {state, lol}, {3'd1, 1'b0}); end
        repeat (5) cyc();
        restart = 1'b1; cyc(); restart = 1'b0;
        n = 0;
        while (pll_rst_n !== 1'b1 && n < 100) begin n++; cyc(); end
        total++; if (n != RST) begin bad++; $display("FAIL restart_mid_hold_cycles: got %0d want %0d", n, RST); end
        repeat (50) cyc();
        en = 1'b0; cyc();
        total++; if ({state, pll_rst_n, ready} !== {3'd0, 2'b00}) begin bad++; $display("FAIL en_low_mid_acq: got %h want %h", {state, pll_rst_n, ready}, {3'd0, 2'b00}); end
        cyc();
        total++; if (state !== 3'd0) begin bad++; $display("FAIL en_low_stays_idle: got %0d want 0", state); end
    endtask

`ifdef PLL_LOCK_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        int t, tr[4], tf;
        tr = '{-1, -1, -1, -1}; tf = -1;
        en = 1'b1; pll_locked = 1'b0;
        t = 0;
        while (tf < 0 && t < 6000) begin
            cyc(); t++;
            for (int r = 1; r <= 3; r++) if (retries == 4'(r) && tr[r] < 0) tr[r] = t;
            if (fail === 1'b1) tf = t;
        end
        for (int r = 1; r <= 3; r++) begin
            total++; if (tr[r] != 1 + r * (RST + TMO)) begin bad++; $display("FAIL timeout_retry_%0d_cycle: got %0d want %0d", r, tr[r], 1 + r * (RST + TMO)); end
        end
        total++; if (tf != 1 + 4 * (RST + TMO)) begin bad++; $display("FAIL timeout_fail_cycle: got %0d want %0d", tf, 1 + 4 * (RST + TMO)); end
        repeat (20) cyc();
        total++; if ({state, fail, pll_rst_n, retries} !== {3'd4, 1'b1, 1'b0, 4'd3}) begin bad++; $display("FAIL fail_hold: got %h want %h", {state, fail, pll_rst_n, retries}, {3'd4, 1'b1, 1'b0, 4'd3}); end
        restart = 1'b1; cyc(); restart = 1'b0;
        total++; if ({state, fail, retries, lol} !== {3'd1, 1'b0, 4'd0, 1'b0}) begin bad++; $display("FAIL fail_restart: got %h want %h", {state, fail, retries, lol}, {3'd1, 1'b0, 4'd0, 1'b0}); end
    endtask
`else
    task automatic test_no_timeout();
        en = 1'b1; pll_locked = 1'b0;
        repeat (3000) cyc();
        total++; if ({state, fail, retries} !== {3'd2, 1'b0, 4'd0}) begin bad++; $display("FAIL no_timeout_waits: got %h want %h", {state, fail, retries}, {3'd2, 1'b0, 4'd0}); end
    endtask
`endif

    task automatic test_random();
        logic [11:0] got, exp;
        int low_burst = 0;
        int errs = 0;
        for (int i = 0; i < 8000; i++) begin
            en      = ($urandom % 1500) != 0;
            restart = ($urandom % 900) == 0;
            if (low_burst == 0 && ($urandom % 1500) == 0) low_burst = $urandom_range(20, 1200);
            if (low_burst > 0) begin
                pll_locked = ($urandom % 20) == 0;
                low_burst--;
            end else begin
                pll_locked = ($urandom % 700) != 0;
            end
            cyc();
            got = {state, pll_rst_n, out_en, ready, fail, lol, retries};
            exp = {m_mode[2:0], (m_mode == M_ACQ || m_mode == M_RUN), (m_mode == M_RUN),
                   (m_mode == M_RUN), (m_mode == M_FAIL), m_lol, m_ret[3:0]};
            total++;
            if (got !== exp) begin
                bad++;
                if (errs < 10) $display("FAIL random_cycle_%0d: got %h want %h", i, got, exp);
                errs++;
            end
        end
        restart = 1'b0; en = 1'b1;
    endtask

    task automatic test_async_reset();
        int k;
        en = 1'b1; pll_locked = 1'b1;
        restart = 1'b1; cyc(); restart = 1'b0;
        k = 0;
        while (ready !== 1'b1 && k < 1000) begin cyc(); k++; end
        total++; if (ready !== 1'b1) begin bad++; $display("FAIL async_pre_run: got %b want 1", ready); end
        #3 rst_n = 1'b0;
        #1;
        model_reset();
        total++; if ({state, pll_rst_n, out_en, ready, fail, lol, retries} !== 12'h0) begin bad++; $display("FAIL async_reset_immediate: got %h want 000", {state, pll_rst_n, out_en, ready, fail, lol, retries}); end
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        total++; if (state !== 3'd1) begin bad++; $display("FAIL async_release_hold: got %0d want 1", state); end
    endtask

    initial begin
        test_reset();
        test_startup();
        test_streak();
        test_lol();
        test_en_restart();
`ifdef PLL_LOCK_CTRL_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
